// File: rtl/uart_alu_sequencer.sv
// -----------------------------------------------------------------------------
// uart_alu_sequencer
//
// Purpose:
//   Collects a three-byte command frame from a UART receiver (operand A,
//   operand B, opcode), presents it to an external combinational ALU,
//   captures the ALU result and hands it to a UART transmitter. It then
//   waits for the transmitter to finish before accepting the next frame.
//   An inter-byte timeout aborts half-received frames. Bytes that arrive
//   while a result is being processed or sent are dropped and flagged.
//
// Parameters:
//   NB_DATA  byte / operand width
//   NB_OP    opcode width (taken from the low bits of the opcode byte)
//   TIMEOUT  inter-byte timeout in clock cycles (>= 2)
//
// Ports:
//   i_clk          single clock, all logic on its rising edge
//   i_rst          synchronous, active-high reset
//   i_rx_data      byte from the UART receiver
//   i_rx_done      receiver byte-valid (level or pulse; rising edge counts)
//   i_alu_result   combinational ALU result
//   o_alu_a        operand A to the ALU
//   o_alu_b        operand B to the ALU
//   o_alu_op       opcode to the ALU
//   o_tx_data      byte to the UART transmitter
//   o_tx_start     one-cycle transmit request
//   i_tx_done      transmitter finished pulse
//   o_busy         high whenever the sequencer is not idle
//   o_err_timeout  one-cycle pulse when a partial frame is aborted
//   o_overrun      one-cycle pulse when a received byte is dropped
// -----------------------------------------------------------------------------
module uart_alu_sequencer #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6,
  parameter int TIMEOUT = 1000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_err_timeout,
  output logic               o_overrun
);

  // Counter only ever needs to hold 0 .. TIMEOUT-1.
  localparam int NB_CNT = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

  state_t              state_reg;
  state_t              state_next;

  logic                rx_prev_reg;
  logic                byte_event;

  logic [NB_CNT-1:0]   cnt_reg;
  logic [NB_CNT-1:0]   cnt_next;

  logic [NB_DATA-1:0]  alu_a_reg;
  logic [NB_DATA-1:0]  alu_b_reg;
  logic [NB_OP-1:0]    alu_op_reg;
  logic [NB_DATA-1:0]  tx_data_reg;
  logic                err_timeout_reg;
  logic                overrun_reg;

  // Load enables / pulse requests produced by the next-state logic.
  logic                load_a;
  logic                load_b;
  logic                load_op;
  logic                load_tx;
  logic                timeout_fire;
  logic                overrun_next;

  // A byte is only recognised on a 0->1 transition of i_rx_done, so a
  // receiver that holds its valid flag high yields exactly one byte.
  assign byte_event = i_rx_done & ~rx_prev_reg;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    cnt_next     = '0;
    load_a       = 1'b0;
    load_b       = 1'b0;
    load_op      = 1'b0;
    load_tx      = 1'b0;
    timeout_fire = 1'b0;
    overrun_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (byte_event) begin
          load_a     = 1'b1;
          state_next = ST_WAIT_B;
        end
      end

      ST_WAIT_B: begin
        // A byte arriving on the threshold cycle takes priority over
        // the timeout.
        if (byte_event) begin
          load_b     = 1'b1;
          state_next = ST_WAIT_OP;
        end else if (cnt_reg == CNT_LAST) begin
          timeout_fire = 1'b1;
          state_next   = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + NB_CNT'(1);
        end
      end

      ST_WAIT_OP: begin
        if (byte_event) begin
          load_op    = 1'b1;
          state_next = ST_EXEC;
        end else if (cnt_reg == CNT_LAST) begin
          timeout_fire = 1'b1;
          state_next   = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + NB_CNT'(1);
        end
      end

      ST_EXEC: begin
        // Operands became valid at the end of the opcode cycle, so the
        // ALU result is settled here.
        load_tx      = 1'b1;
        overrun_next = byte_event;
        state_next   = ST_SEND;
      end

      ST_SEND: begin
        // i_tx_done is deliberately not looked at here: a done pulse
        // from a previous transfer must not complete this one.
        overrun_next = byte_event;
        state_next   = ST_WAIT_TX;
      end

      ST_WAIT_TX: begin
        overrun_next = byte_event;
        if (i_tx_done) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Edge detector, timeout counter, datapath and status pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_prev_reg     <= 1'b0;
      cnt_reg         <= '0;
      alu_a_reg       <= '0;
      alu_b_reg       <= '0;
      alu_op_reg      <= '0;
      tx_data_reg     <= '0;
      err_timeout_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      rx_prev_reg     <= i_rx_done;
      cnt_reg         <= cnt_next;
      err_timeout_reg <= timeout_fire;
      overrun_reg     <= overrun_next;
      if (load_a) begin
        alu_a_reg <= i_rx_data;
      end
      if (load_b) begin
        alu_b_reg <= i_rx_data;
      end
      if (load_op) begin
        alu_op_reg <= i_rx_data[NB_OP-1:0];
      end
      if (load_tx) begin
        tx_data_reg <= i_alu_result;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_alu_a       = alu_a_reg;
  assign o_alu_b       = alu_b_reg;
  assign o_alu_op      = alu_op_reg;
  assign o_tx_data     = tx_data_reg;
  assign o_tx_start    = (state_reg == ST_SEND);
  assign o_busy        = (state_reg != ST_IDLE);
  assign o_err_timeout = err_timeout_reg;
  assign o_overrun     = overrun_reg;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_uart_alu_sequencer
//
// Drives random and directed command frames into uart_alu_sequencer, with a
// small ALU model answering the DUT's operand outputs and a transmitter model
// answering o_tx_start. Expected transmit requests, timeout pulses and
// overrun pulses are queued (with the cycle they must appear in) as the
// stimulus is issued; an independent monitor checks every cycle against the
// heads of those queues.
// -----------------------------------------------------------------------------
module tb_uart_alu_sequencer;

  localparam int TO = 16;

  logic       i_clk;
  logic       i_rst;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic [7:0] i_alu_result;
  logic [7:0] o_alu_a;
  logic [7:0] o_alu_b;
  logic [5:0] o_alu_op;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       i_tx_done;
  logic       o_busy;
  logic       o_err_timeout;
  logic       o_overrun;

  uart_alu_sequencer #(
    .NB_DATA (8),
    .NB_OP   (6),
    .TIMEOUT (TO)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_rx_data     (i_rx_data),
    .i_rx_done     (i_rx_done),
    .i_alu_result  (i_alu_result),
    .o_alu_a       (o_alu_a),
    .o_alu_b       (o_alu_b),
    .o_alu_op      (o_alu_op),
    .o_tx_data     (o_tx_data),
    .o_tx_start    (o_tx_start),
    .i_tx_done     (i_tx_done),
    .o_busy        (o_busy),
    .o_err_timeout (o_err_timeout),
    .o_overrun     (o_overrun)
  );

  // ---------------------------------------------------------------------------
  // Clock, cycle counter, bookkeeping
  // ---------------------------------------------------------------------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int tests  = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference ALU (used both as the external ALU and to predict results)
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return 8'($signed(a) >>> b[2:0]);
      6'h02:   return a >> b[2:0];
      default: return 8'h00;
    endcase
  endfunction

  always_comb i_alu_result = ref_alu(o_alu_a, o_alu_b, o_alu_op);

  // ---------------------------------------------------------------------------
  // Scoreboard queues
  // ---------------------------------------------------------------------------
  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] tx;
  } tx_exp_t;

  tx_exp_t tx_q[$];
  int      err_q[$];
  int      ovr_q[$];

  // ---------------------------------------------------------------------------
  // Monitor: every cycle, compare the three pulse outputs with the queues
  // ---------------------------------------------------------------------------
  initial begin
    tx_exp_t e;
    logic    exp_start;
    logic    exp_err;
    logic    exp_ovr;
    forever begin
      @(posedge i_clk);
      #1;
      if (mon_en) begin
        exp_start = (tx_q.size() > 0) && (tx_q[0].cyc == cyc);
        check("tx_start", o_tx_start, exp_start);
        if (exp_start) begin
          e = tx_q.pop_front();
          check("tx_data", o_tx_data, e.tx);
          check("alu_a", o_alu_a, e.a);
          check("alu_b", o_alu_b, e.b);
          check("alu_op", o_alu_op, e.op);
          $display("[TB] frame a=%02h b=%02h op=%02h -> tx=%02h at cycle %0d",
                   e.a, e.b, e.op, o_tx_data, cyc);
        end else if (tx_q.size() > 0 && tx_q[0].cyc < cyc) begin
          void'(tx_q.pop_front());
        end

        exp_err = (err_q.size() > 0) && (err_q[0] == cyc);
        check("err_timeout", o_err_timeout, exp_err);
        if (err_q.size() > 0 && err_q[0] <= cyc) void'(err_q.pop_front());

        exp_ovr = (ovr_q.size() > 0) && (ovr_q[0] == cyc);
        check("overrun", o_overrun, exp_ovr);
        if (ovr_q.size() > 0 && ovr_q[0] <= cyc) void'(ovr_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmitter model: answers o_tx_start with i_tx_done after resp_delay
  // cycles; optionally also fires a bogus done during the SEND cycle.
  // ---------------------------------------------------------------------------
  int resp_delay = 2;
  bit resp_early = 1'b0;

  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (mon_en && o_tx_start === 1'b1) begin
        if (resp_early) i_tx_done = 1'b1;
        @(posedge i_clk);
        #1;
        i_tx_done = 1'b0;
        check("busy_after_send", o_busy, 1'b1);
        for (int i = 1; i < resp_delay; i++) begin
          @(posedge i_clk);
          #1;
        end
        i_tx_done = 1'b1;
        @(posedge i_clk);
        #1;
        i_tx_done = 1'b0;
        check("idle_after_tx_done", o_busy, 1'b0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called at posedge + #1)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick(1);
  endtask

  // Byte event happens in the calling cycle; returns two cycles later with
  // i_rx_done low for one full cycle so the next call is a fresh edge.
  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    tick(1);
    i_rx_done = 1'b0;
    tick(1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && o_busy !== 1'b0; i++) tick(1);
    check("idle_reached", o_busy, 1'b0);
  endtask

  task automatic check_regs(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [5:0] op, input logic [7:0] tx);
    check({tag, "_a"}, o_alu_a, a);
    check({tag, "_b"}, o_alu_b, b);
    check({tag, "_op"}, o_alu_op, op);
    check({tag, "_tx"}, o_tx_data, tx);
  endtask

  // Full frame; ovr_k >= 2 injects an extra byte ovr_k cycles after the
  // opcode byte event, which must be dropped.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           input int gap, input int d, input bit early, input int ovr_k);
    tx_exp_t e;
    int      n;
    resp_delay = d;
    resp_early = early;
    send_byte(a);
    tick(gap);
    send_byte(b);
    tick(gap);
    n = cyc;
    e.cyc = n + 2;
    e.a   = a;
    e.b   = b;
    e.op  = opb[5:0];
    e.tx  = ref_alu(a, b, opb[5:0]);
    tx_q.push_back(e);
    send_byte(opb);
    if (ovr_k >= 2) begin
      wait_to(n + ovr_k);
      ovr_q.push_back(n + ovr_k + 1);
      send_byte(8'($urandom));
      $display("[TB] overrun byte injected at opcode+%0d", ovr_k);
    end
    wait_idle();
    check_regs("hold", e.a, e.b, e.op, e.tx);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] ops[8];
    int n;
    int n2;
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

    i_rst     = 1'b1;
    i_rx_data = 8'h00;
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    tick(3);
    i_rst = 1'b0;
    check_regs("reset", 8'h00, 8'h00, 6'h00, 8'h00);
    check("reset_tx_start", o_tx_start, 1'b0);
    check("reset_busy", o_busy, 1'b0);
    check("reset_err", o_err_timeout, 1'b0);
    check("reset_ovr", o_overrun, 1'b0);
    mon_en = 1'b1;
    tick(2);

    // Basic frame 05 03 20 -> 08
    run_frame(8'h05, 8'h03, 8'h20, 0, 3, 1'b0, 0);
    check_regs("basic", 8'h05, 8'h03, 6'h20, 8'h08);

    // Done during SEND is ignored, overrun during SEND and WAIT_TX
    run_frame(8'h9A, 8'h13, 8'h22, 1, 3, 1'b1, 0);
    run_frame(8'h40, 8'h02, 8'h25, 0, 4, 1'b0, 2);
    run_frame(8'h77, 8'h0F, 8'h24, 2, 5, 1'b0, 5);

    // Receiver valid held high: one capture only, then timeout in WAIT_B
    n = cyc;
    err_q.push_back(n + TO + 1);
    i_rx_data = 8'h11;
    i_rx_done = 1'b1;
    wait_to(n + 10);
    check("held_busy", o_busy, 1'b1);
    check("held_a", o_alu_a, 8'h11);
    wait_to(n + 50);
    i_rx_done = 1'b0;
    tick(2);
    check("held_a_final", o_alu_a, 8'h11);
    check("held_idle", o_busy, 1'b0);
    $display("[TB] held rx_done: a=%02h busy=%0b", o_alu_a, o_busy);

    // Timeout in WAIT_B, operands retained, next byte taken as A
    n = cyc;
    err_q.push_back(n + TO + 1);
    send_byte(8'h5C);
    wait_to(n + TO + 3);
    check("to_b_idle", o_busy, 1'b0);
    check("to_b_a", o_alu_a, 8'h5C);
    run_frame(8'hC3, 8'h21, 8'h26, 0, 1, 1'b0, 0);

    // Timeout in WAIT_OP
    send_byte(8'h01);
    n = cyc;
    err_q.push_back(n + TO + 1);
    send_byte(8'h02);
    wait_to(n + TO + 3);
    check("to_op_idle", o_busy, 1'b0);
    check("to_op_b", o_alu_b, 8'h02);
    $display("[TB] timeout frames done");

    // Byte on the threshold cycle of both wait states wins
    resp_delay = 2;
    resp_early = 1'b0;
    n = cyc;
    send_byte(8'h31);
    wait_to(n + TO);
    n2 = cyc;
    send_byte(8'h12);
    wait_to(n2 + TO);
    tx_q.push_back('{cyc: n2 + TO + 2, a: 8'h31, b: 8'h12, op: 6'h22, tx: 8'h1F});
    send_byte(8'h22);
    wait_idle();
    check("thresh_b", o_alu_b, 8'h12);

    // Reset while in WAIT_OP discards the frame
    send_byte(8'h33);
    send_byte(8'h44);
    check("pre_reset_busy", o_busy, 1'b1);
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    check_regs("midreset", 8'h00, 8'h00, 6'h00, 8'h00);
    check("midreset_busy", o_busy, 1'b0);
    check("midreset_start", o_tx_start, 1'b0);
    tick(3);
    run_frame(8'hFF, 8'h01, 8'h02, 0, 2, 1'b0, 0);
    check_regs("postreset", 8'hFF, 8'h01, 6'h02, 8'h7F);

    // Random frames
    for (int k = 0; k < 25; k++) begin
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] opb;
      int d;
      int ok;
      a   = 8'($urandom);
      b   = 8'($urandom);
      opb = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {2'($urandom), ops[$urandom_range(0, 7)][5:0]};
      d   = $urandom_range(1, 6);
      ok  = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 2 + d) : 0;
      run_frame(a, b, opb, $urandom_range(0, 4), d, 1'($urandom), ok);
      tick($urandom_range(0, 3));
    end

    tick(30);
    check("tx_queue_drained", tx_q.size(), 0);
    check("err_queue_drained", err_q.size(), 0);
    check("ovr_queue_drained", ovr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
